// File: rtl/dmem_ctrl.sv
// Data-memory controller: single-outstanding valid/ready access to on-chip word storage
// with byte-lane stores, extended loads and misaligned/range/size error reporting.
//
// state  | meaning
// IDLE   | ready for a request; stores/errors go straight to RESP
// ACCESS | load in flight, storage read latency counting down
// RESP   | response presented until resp_ready
module dmem_ctrl #(
   parameter int                DATA_W     = 64,
   parameter int                ADDR_W     = 64,
   parameter int                DEPTH_LOG2 = 13,
   parameter logic [ADDR_W-1:0] BASE_ADDR  = ADDR_W'(64'h8000_0000),
   parameter int                RD_LAT     = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_we,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   input  logic [1:0]        req_size,
   input  logic              req_signed,
   output logic              resp_valid,
   input  logic              resp_ready,
   output logic [DATA_W-1:0] resp_rdata,
   output logic              resp_err
);
   localparam int              NB    = DATA_W / 8;
   localparam int              LG_NB = $clog2(NB);
   localparam logic [ADDR_W:0] SPAN  = (ADDR_W + 1)'(NB) << DEPTH_LOG2;

   typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
   state_t state, nxt;

   logic [DATA_W-1:0]     mem [2**DEPTH_LOG2];
   logic [DATA_W-1:0]     rd_pipe [RD_LAT];
   logic [ADDR_W-1:0]     off;
   logic [LG_NB-1:0]      boff, off_q;
   logic [DEPTH_LOG2-1:0] widx;
   logic [NB-1:0]         be;
   logic [DATA_W-1:0]     wsh, raw, ext;
   logic [1:0]            sz_q, cnt;
   logic                  sgn_q, misal, oor, illegal, err_in, accept, sbit;

   assign off     = req_addr - BASE_ADDR;
   assign boff    = req_addr[LG_NB-1:0];
   assign widx    = off[LG_NB +: DEPTH_LOG2];
   // Subtraction wraps below BASE_ADDR, so the explicit compare catches it first.
   assign oor     = (req_addr < BASE_ADDR) || ({1'b0, off} >= SPAN);
   assign illegal = 32'(req_size) > LG_NB;
   assign err_in  = misal | oor | illegal;
   assign accept  = req_valid & req_ready;
   assign wsh     = req_wdata << {boff, 3'b000};
   assign raw     = rd_pipe[RD_LAT-1] >> {off_q, 3'b000};

   always_comb begin
      misal = 1'b0;
      case (req_size)
         2'd1:    misal = req_addr[0];
         2'd2:    misal = |req_addr[1:0];
         2'd3:    misal = |req_addr[2:0];
         default: misal = 1'b0;
      endcase
      be = '0;
      for (int b = 0; b < NB; b++)
         be[b] = (b >= int'(boff)) && (b < int'(boff) + (1 << req_size));
   end

   always_comb begin
      sbit = 1'b0;
      case (sz_q)
         2'd0:    sbit = raw[7];
         2'd1:    sbit = raw[15];
         2'd2:    sbit = raw[31];
         default: sbit = raw[DATA_W-1];
      endcase
      sbit = sbit & sgn_q;
      ext  = '0;
      for (int i = 0; i < DATA_W; i++)
         ext[i] = (i < (8 << sz_q)) ? raw[i] : sbit;
   end

   // Storage is never reset so it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (accept && !err_in) begin
         if (req_we) begin
            for (int b = 0; b < NB; b++)
               if (be[b]) mem[widx][8*b +: 8] <= wsh[8*b +: 8];
         end else begin
            rd_pipe[0] <= mem[widx];
         end
      end
      for (int i = 1; i < RD_LAT; i++)
         rd_pipe[i] <= rd_pipe[i-1];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= nxt;
   end

   always_comb begin
      nxt = state;
      case (state)
         IDLE:    if (req_valid) nxt = (err_in || req_we) ? RESP : ACCESS;
         ACCESS:  if (cnt == 2'd0) nxt = RESP;
         RESP:    if (resp_ready) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   always_comb begin
      req_ready  = (state == IDLE);
      resp_valid = (state == RESP);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt        <= '0;
         off_q      <= '0;
         sz_q       <= '0;
         sgn_q      <= 1'b0;
         resp_rdata <= '0;
         resp_err   <= 1'b0;
      end else if (accept) begin
         cnt        <= 2'(RD_LAT - 1);
         off_q      <= boff;
         sz_q       <= req_size;
         sgn_q      <= req_signed;
         resp_rdata <= '0;
         resp_err   <= err_in;
      end else if (state == ACCESS) begin
         if (cnt == 2'd0) resp_rdata <= ext;
         else             cnt <= cnt - 2'd1;
      end
   end
endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Parametrised data-memory controller that replaces the fixed 64-bit, always-ready data RAM.
- Generalised in data width, depth, base address and read latency.
- Adds a valid/ready request/response handshake, byte-lane extraction for loads, sign or zero extension, and misaligned / out-of-range error reporting.
- Sits between the LSU/MEM stage and on-chip storage; one outstanding request at a time.

Parameters:
DATA_W, 64, data bus width in bits; legal values 32 or 64; NB = DATA_W/8 bytes per word
ADDR_W, 64, request address width
DEPTH_LOG2, 13, log2 of word count; storage is 2**DEPTH_LOG2 words of DATA_W bits
BASE_ADDR, 64'h8000_0000, byte address of word 0
RD_LAT, 1, storage read latency in cycles; legal values 1 or 2

Ports:
clk  in  1  clock, all state on posedge
rst  in  1  asynchronous active-high reset
req_valid  in  1  request present
req_ready  out  1  controller accepts request this cycle
req_we  in  1  1 = store, 0 = load
req_addr  in  ADDR_W  byte address
req_wdata  in  DATA_W  store data, right-aligned (bits [8*2^size-1:0] used)
req_size  in  2  0 = byte, 1 = half, 2 = word32, 3 = dword64 (3 is illegal when DATA_W = 32)
req_signed  in  1  loads: 1 = sign-extend, 0 = zero-extend
resp_valid  out  1  response available
resp_ready  in  1  consumer takes response
resp_rdata  out  DATA_W  extended load data; 0 for stores and errors
resp_err  out  1  misaligned, out-of-range or illegal-size request

Behaviour:
- Reset, asynchronous and immediate:
  - FSM returns to IDLE.
  - req_ready=1, resp_valid=0, resp_rdata=0, resp_err=0.
  - Latency counter cleared.
  - Storage contents are not cleared.
- FSM states: IDLE, ACCESS, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid, capture we, addr low bits, size, signed and the error flag.
  - Error or store: go to RESP. Load: go to ACCESS.
- Error checks, combinational at accept:
  - misaligned: addr mod 2^size != 0
  - out of range: addr < BASE_ADDR, or addr - BASE_ADDR >= NB * 2**DEPTH_LOG2
  - illegal: size > log2(NB)
  - Any check true: err=1, no storage access, no write.
- Store (no error):
  - Written on the accept edge.
  - Word index = (addr - BASE_ADDR) >> log2(NB).
  - Byte enable = ((1 << 2^size) - 1) << addr[log2(NB)-1:0].
  - Data is shifted left by 8 * offset.
  - Response follows one cycle later with rdata=0, err=0.
- Load (no error):
  - Storage read is issued on the accept edge.
  - ACCESS lasts RD_LAT cycles (down-counter).
  - Then the lane at byte offset is extracted, extended per req_signed to DATA_W, and RESP is entered.
  - First resp_valid is RD_LAT+1 cycles after acceptance.
- RESP:
  - resp_valid=1; rdata and err are held stable while resp_ready=0.
  - On resp_ready, go to IDLE.
  - req_ready stays 0 in ACCESS and RESP, so there is no same-cycle accept on response retirement.
  - Minimum spacing: 2 cycles per store, RD_LAT+2 cycles per load.
- Read-after-write: a load accepted after a store's response returns the new data.
- Reset during ACCESS or RESP: response is dropped. A store already accepted remains written.
- Address arithmetic is unsigned ADDR_W. Wrap-around below BASE_ADDR is caught by the range check, not aliased.
- DATA_W = 32: size 3 is flagged illegal, and offset uses addr[1:0].

Test Plan:
- Store dword 64'h1122_3344_5566_7788 @0x8000_0000; then load size 3 -> resp_rdata = 64'h1122334455667788, err=0; resp_valid exactly RD_LAT+1 cycles after accept (RD_LAT=1 and 2).
- Store byte 8'hF0 @0x8000_0005; then load byte signed @0x8000_0005 -> 64'hFFFF_FFFF_FFFF_FFF0; unsigned -> 64'h0000_0000_0000_00F0; load dword @0x8000_0000 -> 64'h1122_F044_5566_7788 (neighbouring bytes untouched).
- Load word @0x8000_0006 -> err=1, rdata=0; store half @0x8000_0003 -> err=1 and storage unchanged on readback.
- Load @0x7FFF_FFF8 and @BASE_ADDR + NB*2**DEPTH_LOG2 -> err=1; load @ last word -> err=0.
- resp_ready held 0 for 5 cycles -> resp_valid, rdata and err stable; req_ready=0 throughout; req_ready=1 the cycle after the handshake.
- Assert rst during ACCESS -> resp_valid=0 immediately, req_ready=1; next load returns correct data.
